// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

    localparam int SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first, one bit per clock,
// and publishes the aligned result with the final borrow when the last bit is done.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             d_bit;
    logic             bout_bit;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            ST_RUN: begin
                res_d    = {d_bit, res_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = bout_bit;
                // Counter parks at the last bit index instead of wrapping.
                if (cnt_q == LAST_BIT) begin
                    state_d      = ST_DONE;
                    diff_d       = {d_bit, res_q[WIDTH-1:1]};
                    borrow_out_d = bout_bit;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) plus an exhaustive
// back-to-back sweep of a WIDTH=4 instance against a reference model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, borrow_out;
    logic [7:0] diff;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, borrow_out4;
    logic [3:0] diff4;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow_out4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation; optional re-pulse of start with a=9,b=1 mid-run.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input bit repulse);
        int busy_cnt;
        int done_cnt;
        logic [7:0] prev;
        prev = diff;
        a = av; b = bv; start = 1'b1;
        step();
        start = 1'b0; a = ~av; b = ~bv;
        busy_cnt = 0; done_cnt = 0;
        for (int j = 0; j < 8; j++) begin
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (j == 4) check({tag, "_diff_hold"}, 32'(diff), 32'(prev));
            if (repulse && j == 2) begin start = 1'b1; a = 8'd9; b = 8'd1; end
            if (repulse && j == 3) start = 1'b0;
            step();
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_early_done"}, 32'(done_cnt), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
        step();
        check({tag, "_done_low"}, 32'(done), 32'd0);
        if (repulse) begin
            done_cnt = 0;
            for (int j = 0; j < 12; j++) begin
                done_cnt += int'(done);
                step();
            end
            check({tag, "_extra_done"}, 32'(done_cnt), 32'd0);
            check({tag, "_diff_final"}, 32'(diff), 32'(ed));
        end
    endtask

    initial begin
        int n;
        int done_cnt;
        int pa, pb;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        step();
        rst = 1'b0;

        run_op("op_5_3",     8'd5,   8'd3,   8'd2,    1'b0, 1'b0);
        run_op("op_3_5",     8'd3,   8'd5,   8'hFE,   1'b1, 1'b0);
        run_op("op_0_1",     8'd0,   8'd1,   8'hFF,   1'b1, 1'b0);
        run_op("op_255_255", 8'd255, 8'd255, 8'd0,    1'b0, 1'b0);
        run_op("op_0_0",     8'd0,   8'd0,   8'd0,    1'b0, 1'b0);
        run_op("op_255_0",   8'd255, 8'd0,   8'hFF,   1'b0, 1'b0);
        run_op("repulse",    8'd5,   8'd3,   8'd2,    1'b0, 1'b1);

        // Abort in the fourth RUN cycle.
        a = 8'd200; b = 8'd100; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            done_cnt += int'(done);
            step();
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_diff_idle", 32'(diff), 32'd0);
        run_op("rerun_200_100", 8'd200, 8'd100, 8'd100, 1'b0, 1'b0);

        // WIDTH=4 exhaustive sweep with start held high.
        a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
        for (int p = 0; p < 256; p++) begin
            pa = p / 16;
            pb = p % 16;
            n = 0;
            do begin
                step();
                n++;
            end while (!done4 && n < 12);
            check($sformatf("w4_done_%0d_%0d", pa, pb), 32'(done4), 32'd1);
            check($sformatf("w4_diff_%0d_%0d", pa, pb), 32'(diff4), 32'((pa - pb) & 15));
            check($sformatf("w4_borrow_%0d_%0d", pa, pb), 32'(borrow_out4), 32'(pa < pb));
            if (p > 0) check($sformatf("w4_period_%0d_%0d", pa, pb), 32'(n), 32'd6);
            if (p < 255) begin
                a4 = 4'((p + 1) / 16);
                b4 = 4'((p + 1) % 16);
            end
        end
        start4 = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
